// File: rtl/dk_pkg.sv
// dk_pkg: state encoding and default timing for the AGC downlink receiver.
// Rates assume a 51.2 MHz propagation clock and a 51.2 kHz bit rate.
package dk_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_END,
        S_WAIT
    } dk_state_e;

    localparam int DK_WORD_BITS      = 40;
    localparam int DK_BIT_DIV        = 1000;
    localparam int DK_PULSE_W        = 20;
    localparam int DK_SAMPLE_DLY     = 500;
    localparam int DK_WORD_PERIOD_50 = 1024000;
    localparam int DK_WORD_PERIOD_10 = 5120000;

endpackage

// File: rtl/dk_out_buf.sv
// dk_out_buf: one-deep valid/ready word buffer with sticky overrun flag.
// Optional DKRX_WORDNUM_EN carries a 16-bit sequence number with each word.
module dk_out_buf
    import dk_pkg::*;
#(
    parameter int W = DK_WORD_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    input  logic         i_clr,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_ovr
`ifdef DKRX_WORDNUM_EN
    ,
    input  logic [15:0]  i_num,
    output logic [15:0]  o_num
`endif
);

    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_ovr;
    logic         w_load;
    logic         w_drop;
    logic         w_take;

    // A push with ready high in the same cycle replaces the old word.
    assign w_take = r_valid & i_ready;
    assign w_load = i_push & (~r_valid | i_ready);
    assign w_drop = i_push & r_valid & ~i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (i_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

`ifdef DKRX_WORDNUM_EN
    logic [15:0] r_num;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num <= '0;
        end else if (w_load) begin
            r_num <= i_num;
        end
    end

    assign o_num = r_num;
`endif

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_ovr   = r_ovr;

endmodule

// File: rtl/dk_downlink_rx.sv
// dk_downlink_rx: AGC downlink strobe generator and 40-bit serial word receiver.
// Define DKRX_WORDNUM_EN to add the word_num sequence output.
module dk_downlink_rx
    import dk_pkg::*;
#(
    parameter int BIT_DIV     = DK_BIT_DIV,
    parameter int PULSE_W     = DK_PULSE_W,
    parameter int SAMPLE_DLY  = DK_SAMPLE_DLY,
    parameter int WORD_BITS   = DK_WORD_BITS,
    parameter int WORD_PERIOD = DK_WORD_PERIOD_50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 dkdata,
    output logic                 dkstrt,
    output logic                 dkbsnc,
    output logic                 dkend,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overrun,
    input  logic                 ovr_clr
`ifdef DKRX_WORDNUM_EN
    ,
    output logic [15:0]          word_num
`endif
);

    localparam int CW = $clog2(BIT_DIV);
    localparam int BW = $clog2(WORD_BITS);
    localparam int PW = $clog2(WORD_PERIOD);

    localparam logic [CW-1:0] C_PLAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] C_PW    = CW'(PULSE_W);
    localparam logic [CW-1:0] C_SLAST = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] C_SAMP  = CW'(PULSE_W + SAMPLE_DLY);
    localparam logic [BW-1:0] C_BLAST = BW'(WORD_BITS - 1);
    localparam logic [PW-1:0] C_PLIM  = PW'(WORD_PERIOD - 1);

    dk_state_e            r_state;
    dk_state_e            w_nstate;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_ncnt;
    logic [BW-1:0]        r_bit;
    logic [BW-1:0]        w_nbit;
    logic [PW-1:0]        r_per;
    logic [PW-1:0]        w_nper;
    logic [WORD_BITS-1:0] r_shift;
    logic                 r_dkstrt;
    logic                 r_dkbsnc;
    logic                 r_dkend;
    logic                 r_push;
    logic                 w_push;

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nbit   = r_bit;
        w_push   = 1'b0;
        w_nper   = (r_per == C_PLIM) ? r_per : r_per + 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_nstate = S_START;
                    w_ncnt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == C_PLAST) begin
                    w_nstate = S_BITS;
                    w_ncnt   = '0;
                    w_nbit   = '0;
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            S_BITS: begin
                if (r_cnt == C_SLAST) begin
                    w_ncnt = '0;
                    if (r_bit == C_BLAST) begin
                        w_nstate = S_END;
                    end else begin
                        w_nbit = r_bit + 1'b1;
                    end
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            S_END: begin
                if (r_cnt == C_PLAST) begin
                    w_nstate = S_WAIT;
                    w_ncnt   = '0;
                    w_push   = 1'b1;
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (r_per == C_PLIM) begin
                    w_nstate = enable ? S_START : S_IDLE;
                    w_ncnt   = '0;
                end
            end
            default: begin
                w_nstate = S_IDLE;
            end
        endcase
        // The period is measured from each dkstrt rise.
        if (w_nstate == S_START && r_state != S_START) begin
            w_nper = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_per    <= '0;
            r_shift  <= '0;
            r_dkstrt <= 1'b0;
            r_dkbsnc <= 1'b0;
            r_dkend  <= 1'b0;
            r_push   <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_bit    <= w_nbit;
            r_per    <= w_nper;
            r_push   <= w_push;
            // Strobes come from next-state values so they are flop outputs
            // aligned exactly with the state they describe.
            r_dkstrt <= (w_nstate == S_START);
            r_dkbsnc <= (w_nstate == S_BITS) && (w_ncnt < C_PW);
            r_dkend  <= (w_nstate == S_END);
            if (r_state == S_BITS && r_cnt == C_SAMP) begin
                r_shift <= {r_shift[WORD_BITS-2:0], dkdata};
            end
        end
    end

`ifdef DKRX_WORDNUM_EN
    logic [15:0] r_wnum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wnum <= '0;
        end else if (r_push) begin
            r_wnum <= r_wnum + 16'd1;
        end
    end
`endif

    dk_out_buf #(
        .W(WORD_BITS)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_data  (r_shift),
        .i_ready (word_ready),
        .i_clr   (ovr_clr),
        .o_data  (word_data),
        .o_valid (word_valid),
        .o_ovr   (overrun)
`ifdef DKRX_WORDNUM_EN
        ,
        .i_num   (r_wnum),
        .o_num   (word_num)
`endif
    );

    assign dkstrt = r_dkstrt;
    assign dkbsnc = r_dkbsnc;
    assign dkend  = r_dkend;

endmodule

// File: tb/tb_dk_downlink_rx.sv
// tb_dk_downlink_rx: directed checks of strobe timing, word capture and buffering.
// Define DKRX_WORDNUM_EN to also check the word_num sequence gap.
module tb_dk_downlink_rx;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        dkdata;
    logic        dkstrt;
    logic        dkbsnc;
    logic        dkend;
    logic [39:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        overrun;
    logic        ovr_clr;
`ifdef DKRX_WORDNUM_EN
    logic [15:0] word_num;
    logic [15:0] num_b;
`endif

    int n_chk = 0;
    int n_bad = 0;

    logic [39:0] pat;
    logic [39:0] cur;
    int          bidx;
    logic        dp_strt;
    logic        dp_bsnc;

    int   cyc = 0;
    int   n_strt = 0;
    int   n_bsnc = 0;
    int   n_end = 0;
    int   t_strt = 0;
    int   t_strt_prev = 0;
    int   t_vrise = 0;
    int   wbad = 0;
    int   ws = 0;
    int   wb = 0;
    int   we = 0;
    logic m_strt = 0;
    logic m_bsnc = 0;
    logic m_end = 0;
    logic m_valid = 0;

    int b_strt;
    int b_bsnc;
    int b_end;
    int b_wbad;

    dk_downlink_rx #(
        .BIT_DIV     (16),
        .PULSE_W     (2),
        .SAMPLE_DLY  (6),
        .WORD_BITS   (40),
        .WORD_PERIOD (800)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .dkdata     (dkdata),
        .dkstrt     (dkstrt),
        .dkbsnc     (dkbsnc),
        .dkend      (dkend),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
`ifdef DKRX_WORDNUM_EN
        ,
        .word_num   (word_num)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe counters, pulse widths and event times, observed mid-cycle.
    always @(negedge clk) begin
        if (dkstrt && !m_strt) begin
            n_strt++;
            t_strt_prev = t_strt;
            t_strt = cyc;
        end
        if (dkbsnc && !m_bsnc) n_bsnc++;
        if (dkend && !m_end) n_end++;
        if (word_valid && !m_valid) t_vrise = cyc;
        if (dkstrt) ws++;
        else if (ws != 0) begin
            if (ws != 2) wbad++;
            ws = 0;
        end
        if (dkbsnc) wb++;
        else if (wb != 0) begin
            if (wb != 2) wbad++;
            wb = 0;
        end
        if (dkend) we++;
        else if (we != 0) begin
            if (we != 2) wbad++;
            we = 0;
        end
        m_strt  = dkstrt;
        m_bsnc  = dkbsnc;
        m_end   = dkend;
        m_valid = word_valid;
    end

    // AGC model: next bit goes out just after each dkbsnc fall, MSB first.
    initial begin
        dkdata  = 1'b0;
        bidx    = 0;
        cur     = '0;
        dp_strt = 1'b0;
        dp_bsnc = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bidx   = 0;
                dkdata = 1'b0;
            end else begin
                if (dkstrt && !dp_strt) begin
                    cur  = pat;
                    bidx = 0;
                end
                if (!dkbsnc && dp_bsnc && bidx < 40) begin
                    dkdata = cur[39-bidx];
                    bidx++;
                end
            end
            dp_strt = dkstrt;
            dp_bsnc = dkbsnc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_strt(input string tag);
        logic pv;
        bit   hit;
        pv  = dkstrt;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (dkstrt && !pv) hit = 1;
            pv = dkstrt;
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (word_valid) hit = 1;
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
        #1;
    endtask

    task automatic wait_end_fall(input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (dkend) hit = 1;
        end
        if (!hit) chk({tag, "_end_timeout"}, 0, 1);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (!dkend) hit = 1;
        end
        if (!hit) chk({tag, "_fall_timeout"}, 0, 1);
        #1;
    endtask

    task automatic consume();
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        word_ready = 1'b0;
        ovr_clr    = 1'b0;
        pat        = 40'hA5_1234_C3F0;
        repeat (4) @(negedge clk);
        chk("rst_strt", dkstrt, 0);
        chk("rst_bsnc", dkbsnc, 0);
        chk("rst_end", dkend, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_data", word_data, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_strt", dkstrt, 0);

        // basic word and strobe timing
        enable = 1'b1;
        wait_strt("w1");
        wait_valid("w1");
        chk("w1_data", word_data, 40'hA5_1234_C3F0);
        chk("w1_lat", t_vrise - t_strt, 645);
        chk("w1_nstrt", n_strt, 1);
        chk("w1_nbsnc", n_bsnc, 40);
        chk("w1_nend", n_end, 1);
        chk("w1_width", wbad, 0);
        chk("w1_ovr", overrun, 0);
        consume();
        chk("w1_taken", word_valid, 0);

        // period, then backpressure across two words
        pat = 40'h12_3456_789A;
        wait_strt("w2");
        chk("period", t_strt - t_strt_prev, 800);
        pat = 40'hFF_0000_FFFF;
        wait_valid("w2");
        chk("w2_data", word_data, 40'h12_3456_789A);
`ifdef DKRX_WORDNUM_EN
        num_b = word_num;
`endif
        wait_strt("w3");
        pat = 40'h0F_1E2D_3C4B;
        wait_end_fall("w3");
        @(negedge clk);
        chk("drop_ovr", overrun, 1);
        chk("drop_valid", word_valid, 1);
        chk("drop_keep", word_data, 40'h12_3456_789A);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        consume();
        chk("w2_taken", word_valid, 0);
        wait_valid("w4");
        chk("w4_data", word_data, 40'h0F_1E2D_3C4B);
`ifdef DKRX_WORDNUM_EN
        chk("num_gap", word_num - num_b, 2);
`endif

        // ready exactly on the completing cycle with an old word pending
        pat = 40'h80_0000_0001;
        wait_end_fall("w5");
        chk("w5_pending", word_valid, 1);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        chk("simul_valid", word_valid, 1);
        chk("simul_data", word_data, 40'h80_0000_0001);
        chk("simul_ovr", overrun, 0);
        consume();

        // enable dropped mid-word
        pat = 40'h5A_5A5A_A5A5;
        wait_strt("w6");
        repeat (162) @(negedge clk);
        enable = 1'b0;
        b_strt = n_strt;
        wait_valid("w6");
        chk("w6_data", word_data, 40'h5A_5A5A_A5A5);
        repeat (300) @(negedge clk);
        #1;
        chk("idle_nstrt", n_strt, b_strt);
        chk("idle_low", dkstrt, 0);
        pat    = 40'hDE_AD00_BEEF;
        enable = 1'b1;
        @(negedge clk);
        chk("reen_strt", dkstrt, 1);

        // reset during bit 20
        repeat (322) @(negedge clk);
        chk("pre_rst_bsnc", dkbsnc, 1);
        chk("pre_rst_valid", word_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bsnc", dkbsnc, 0);
        chk("mid_rst_strt", dkstrt, 0);
        chk("mid_rst_valid", word_valid, 0);
        chk("mid_rst_data", word_data, 0);
        repeat (3) @(negedge clk);
        #1;
        pat    = 40'h3C_C3A5_5A69;
        b_strt = n_strt;
        b_bsnc = n_bsnc;
        b_end  = n_end;
        b_wbad = wbad;
        rst_n  = 1'b1;
        wait_strt("w8");
        wait_valid("w8");
        chk("w8_data", word_data, 40'h3C_C3A5_5A69);
        chk("w8_lat", t_vrise - t_strt, 645);
        chk("w8_nstrt", n_strt - b_strt, 1);
        chk("w8_nbsnc", n_bsnc - b_bsnc, 40);
        chk("w8_nend", n_end - b_end, 1);
        chk("w8_width", wbad - b_wbad, 0);
        chk("w8_ovr", overrun, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
